// File: rtl/sha_state_regfile.sv
// SHA-style working-variable and hash-word register banks with parallel load, single-word
// write, compression-round shift and a multi-cycle feed-forward add through one shared adder.
module sha_state_regfile #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4,
    parameter int ROUNDS   = 64,
    parameter int CNT_W    = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      op_valid,
    input  logic [2:0]                op,
    output logic                      op_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [NUM_REGS*WIDTH-1:0] par_in,
    input  logic [WIDTH-1:0]          t1,
    input  logic [WIDTH-1:0]          t2,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*WIDTH-1:0] vars_out,
    output logic [NUM_REGS*WIDTH-1:0] hash_out,
    output logic [CNT_W-1:0]          round_cnt,
    output logic                      rounds_done,
    output logic                      ff_done,
    output logic                      op_err
);

    localparam int M     = NUM_REGS / 2;
    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_ROUND = 3'd3;
    localparam logic [2:0] OP_INIT  = 3'd4;
    localparam logic [2:0] OP_FEED  = 3'd5;

    typedef enum logic {ST_IDLE, ST_FEED} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0]     vars_q [NUM_REGS];
    logic [WIDTH-1:0]     vars_d [NUM_REGS];
    logic [WIDTH-1:0]     hash_q [NUM_REGS];
    logic [WIDTH-1:0]     hash_d [NUM_REGS];
    logic [WIDTH-1:0]     par_w  [NUM_REGS];
    logic [WIDTH-1:0]     round_w[NUM_REGS];
    logic [CNT_W-1:0]     round_cnt_q, round_cnt_d;
    logic                 rounds_done_q, rounds_done_d;
    logic                 ff_done_q, ff_done_d;
    logic                 op_err_q, op_err_d;
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                 accept, ff_last, wr_ok;
    logic [WIDTH-1:0]     ff_hash, ff_vars, ff_sum;

    // Round shift: A takes T1+T2, the middle word absorbs T1, all others move down one slot.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_words
            assign par_w[gi]                    = par_in[gi*WIDTH +: WIDTH];
            assign vars_out[gi*WIDTH +: WIDTH]  = vars_q[gi];
            assign hash_out[gi*WIDTH +: WIDTH]  = hash_q[gi];
            if (gi == 0) begin : g_a
                assign round_w[gi] = t1 + t2;
            end else if (gi == M) begin : g_mid
                assign round_w[gi] = vars_q[gi-1] + t1;
            end else begin : g_shift
                assign round_w[gi] = vars_q[gi-1];
            end
        end
    endgenerate

    assign accept  = op_valid && op_ready;
    assign ff_last = (ff_idx_q == IDX_W'(NUM_REGS - 1));
    assign wr_ok   = (wr_addr != '0) && (wr_addr <= ADDR_W'(NUM_REGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && op == OP_FEED) state_d = ST_FEED;
            ST_FEED: if (ff_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q == ST_IDLE);
    end

    // Single shared adder for feed-forward, steered by ff_idx.
    always_comb begin
        ff_hash = '0;
        ff_vars = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ff_idx_q == IDX_W'(i)) begin
                ff_hash = hash_q[i];
                ff_vars = vars_q[i];
            end
        end
    end

    assign ff_sum = ff_hash + ff_vars;

    always_comb begin
        vars_d        = vars_q;
        hash_d        = hash_q;
        round_cnt_d   = round_cnt_q;
        rounds_done_d = rounds_done_q;
        op_err_d      = 1'b0;
        ff_done_d     = 1'b0;
        ff_idx_d      = '0;
        rd_data_d     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data_d = vars_q[i];
        end
        if (state_q == ST_FEED) begin
            ff_idx_d  = ff_last ? '0 : ff_idx_q + 1'b1;
            ff_done_d = ff_last;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ff_idx_q == IDX_W'(i)) begin
                    vars_d[i] = ff_sum;
                    hash_d[i] = ff_sum;
                end
            end
        end else if (accept) begin
            case (op)
                OP_NOP: ;
                OP_LOAD: begin
                    vars_d        = par_w;
                    round_cnt_d   = '0;
                    rounds_done_d = 1'b0;
                end
                OP_INIT: begin
                    vars_d        = par_w;
                    hash_d        = par_w;
                    round_cnt_d   = '0;
                    rounds_done_d = 1'b0;
                end
                OP_WRITE: begin
                    if (wr_ok) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (wr_addr == ADDR_W'(i + 1)) vars_d[i] = wr_data;
                        end
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
                OP_ROUND: begin
                    vars_d = round_w;
                    if (round_cnt_q == CNT_W'(ROUNDS - 1)) begin
                        round_cnt_d   = '0;
                        rounds_done_d = 1'b1;
                    end else begin
                        round_cnt_d = round_cnt_q + 1'b1;
                    end
                end
                OP_FEED: ;
                default: op_err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                vars_q[i] <= '0;
                hash_q[i] <= '0;
            end
            ff_idx_q      <= '0;
            round_cnt_q   <= '0;
            rounds_done_q <= 1'b0;
            ff_done_q     <= 1'b0;
            op_err_q      <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            vars_q        <= vars_d;
            hash_q        <= hash_d;
            ff_idx_q      <= ff_idx_d;
            round_cnt_q   <= round_cnt_d;
            rounds_done_q <= rounds_done_d;
            ff_done_q     <= ff_done_d;
            op_err_q      <= op_err_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign round_cnt   = round_cnt_q;
    assign rounds_done = rounds_done_q;
    assign ff_done     = ff_done_q;
    assign op_err      = op_err_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_sha_state_regfile.sv
// Randomised scoreboard bench for sha_state_regfile: the driver predicts each accepted
// operation with an array model and queues it; a monitor pops on each DUT response.
module tb_sha_state_regfile;

    localparam int W      = 32;
    localparam int NR     = 8;
    localparam int AW     = 4;
    localparam int CW     = 7;
    localparam int ROUNDS = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              op_valid = 1'b0;
    logic [2:0]        op = '0;
    logic              op_ready;
    logic [AW-1:0]     wr_addr = '0;
    logic [W-1:0]      wr_data = '0;
    logic [NR*W-1:0]   par_in = '0;
    logic [W-1:0]      t1 = '0;
    logic [W-1:0]      t2 = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [W-1:0]      rd_data;
    logic [NR*W-1:0]   vars_out;
    logic [NR*W-1:0]   hash_out;
    logic [CW-1:0]     round_cnt;
    logic              rounds_done;
    logic              ff_done;
    logic              op_err;

    always #5 clk = ~clk;

    sha_state_regfile #(.WIDTH(W), .NUM_REGS(NR), .ADDR_W(AW), .ROUNDS(ROUNDS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .par_in(par_in), .t1(t1), .t2(t2),
        .rd_addr(rd_addr), .rd_data(rd_data), .vars_out(vars_out), .hash_out(hash_out),
        .round_cnt(round_cnt), .rounds_done(rounds_done), .ff_done(ff_done), .op_err(op_err)
    );

    typedef struct {
        logic [NR*W-1:0] vars;
        logic [NR*W-1:0] hash;
        int              cnt;
        bit              done;
        bit              err;
        bit              chk_rd;
        bit              is_ff;
        logic [W-1:0]    rd;
        int              opc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           ff_seen = 0;
    int           ff_exp = 0;
    int           txn = 0;
    logic [W-1:0] m_vars[NR];
    logic [W-1:0] m_hash[NR];
    int           m_cnt = 0;
    bit           m_done = 1'b0;

    task automatic chk(input string nm, input logic [NR*W-1:0] act, input logic [NR*W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [NR*W-1:0] flat(input logic [W-1:0] a[NR]);
        logic [NR*W-1:0] r;
        for (int i = 0; i < NR; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    function automatic logic [NR*W-1:0] rand_par();
        logic [NR*W-1:0] r;
        for (int i = 0; i < NR; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_vars[i] = '0;
            m_hash[i] = '0;
        end
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    // Monitor: responses appear the cycle after an accepted op, or on ff_done.
    bit         acc_s = 1'b0;
    logic [2:0] acc_op = '0;
    bit         ff_prev = 1'b0;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        acc_s  = rst_n && op_valid && op_ready;
        acc_op = op;
    end

    task automatic pop_check(input bit is_ff);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got response ff=%0d expected none", is_ff);
            return;
        end
        e = exp_q.pop_front();
        chk("resp_kind", NR*W'(is_ff), NR*W'(e.is_ff));
        chk("vars_out", vars_out, e.vars);
        chk("hash_out", hash_out, e.hash);
        chk("round_cnt", NR*W'(round_cnt), NR*W'(e.cnt));
        chk("rounds_done", NR*W'(rounds_done), NR*W'(e.done));
        chk("op_err", NR*W'(op_err), NR*W'(e.err));
        if (e.chk_rd) chk("rd_data", NR*W'(rd_data), NR*W'(e.rd));
        txn++;
        $display("txn %0d op=%0d round_cnt=%0d rounds_done=%0d op_err=%0d",
                 txn, e.opc, round_cnt, rounds_done, op_err);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            ff_prev  = 1'b0;
        end else begin
            if (acc_s && acc_op != 3'd5) pop_check(1'b0);
            if (ff_done) begin
                ff_seen++;
                chk("ff_done_width", NR*W'(ff_prev), '0);
                pop_check(1'b1);
            end
            if (!acc_s) chk("op_err_idle", NR*W'(op_err), '0);
            if (!op_ready) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                chk("feed_busy_cycles", NR*W'(busy_cnt), NR*W'(NR));
                busy_cnt = 0;
            end
            ff_prev = ff_done;
        end
    end

    // Driver: one op per cycle; predicted result is queued when the model accepts it.
    task automatic issue(input bit v, input logic [2:0] o, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic [NR*W-1:0] p,
                         input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [AW-1:0] ra);
        exp_t         e;
        logic [W-1:0] nv[NR];
        int           r;
        int           a;
        @(negedge clk);
        op_valid = v; op = o; wr_addr = wa; wr_data = wd; par_in = p; t1 = a1; t2 = a2; rd_addr = ra;
        if (!v) return;
        r    = int'(ra);
        e.rd = '0;
        if (r < NR) e.rd = m_vars[r];
        e.err = 1'b0;
        case (o)
            3'd1: begin
                for (int i = 0; i < NR; i++) m_vars[i] = p[i*W +: W];
                m_cnt = 0; m_done = 1'b0;
            end
            3'd2: begin
                a = int'(wa);
                if (a >= 1 && a <= NR) m_vars[a-1] = wd;
                else e.err = 1'b1;
            end
            3'd3: begin
                nv[0] = a1 + a2;
                for (int i = 1; i < NR; i++) nv[i] = m_vars[i-1];
                nv[NR/2] = m_vars[NR/2-1] + a1;
                m_vars = nv;
                m_cnt++;
                if (m_cnt == ROUNDS) begin
                    m_cnt  = 0;
                    m_done = 1'b1;
                end
            end
            3'd4: begin
                for (int i = 0; i < NR; i++) begin
                    m_vars[i] = p[i*W +: W];
                    m_hash[i] = p[i*W +: W];
                end
                m_cnt = 0; m_done = 1'b0;
            end
            3'd6, 3'd7: e.err = 1'b1;
            default: ;
        endcase
        e.vars = flat(m_vars); e.hash = flat(m_hash); e.cnt = m_cnt; e.done = m_done;
        e.chk_rd = 1'b1; e.is_ff = 1'b0; e.opc = int'(o);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
    endtask

    task automatic feed(input int abort_at, input bit present_load);
        exp_t e;
        @(negedge clk);
        op_valid = 1'b1; op = 3'd5; rd_addr = AW'($urandom_range(0, 15));
        for (int c = 1; c <= NR; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                op_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("abort_vars", vars_out, '0);
                chk("abort_hash", hash_out, '0);
                chk("abort_round_cnt", NR*W'(round_cnt), '0);
                chk("abort_rounds_done", NR*W'(rounds_done), '0);
                chk("abort_ff_done", NR*W'(ff_done), '0);
                chk("abort_op_err", NR*W'(op_err), '0);
                chk("abort_rd_data", NR*W'(rd_data), '0);
                model_reset();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                #1 chk("ready_after_reset", NR*W'(op_ready), NR*W'(1));
                return;
            end
            if (present_load && c == 3) begin
                op_valid = 1'b1; op = 3'd1; par_in = rand_par();
            end else begin
                op_valid = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 7));
                wr_addr = AW'($urandom_range(0, 15)); wr_data = $urandom; par_in = rand_par();
                t1 = $urandom; t2 = $urandom;
            end
        end
        op_valid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_hash[i] = m_hash[i] + m_vars[i];
            m_vars[i] = m_hash[i];
        end
        e.vars = flat(m_vars); e.hash = flat(m_hash); e.cnt = m_cnt; e.done = m_done;
        e.err = 1'b0; e.chk_rd = 1'b0; e.is_ff = 1'b1; e.rd = '0; e.opc = 5;
        exp_q.push_back(e);
        ff_exp++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NR*W-1:0] iv;
        logic [NR*W-1:0] p;
        logic [2:0]      o;
        int              sel;
        iv = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
              32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_vars", vars_out, '0);
        chk("reset_hash", hash_out, '0);
        chk("reset_round_cnt", NR*W'(round_cnt), '0);
        chk("reset_flags", NR*W'({rounds_done, ff_done, op_err}), '0);
        chk("reset_rd_data", NR*W'(rd_data), '0);
        rst_n = 1'b1;
        #1 chk("reset_ready", NR*W'(op_ready), NR*W'(1));

        issue(1, 3'd1, 0, 0, iv, 0, 0, 0);
        issue(1, 3'd3, 0, 0, 0, 32'h00000001, 32'hffffffff, 4'd1);

        issue(1, 3'd1, 0, 0, iv, 0, 0, 0);
        for (int i = 0; i < ROUNDS; i++) issue(1, 3'd3, 0, 0, 0, $urandom, $urandom, AW'(i % 16));
        issue(1, 3'd1, 0, 0, iv, 0, 0, 4'd2);

        p = {NR{32'h00000010}};
        issue(1, 3'd4, 0, 0, p, 0, 0, 0);
        issue(1, 3'd2, 4'd3, 32'h00000005, 0, 0, 0, 4'd2);
        feed(0, 1'b1);
        idle(2);

        issue(1, 3'd2, 4'd0, 32'hdeadbeef, 0, 0, 0, 4'd9);
        issue(1, 3'd2, 4'd9, 32'hdeadbeef, 0, 0, 0, 4'd9);
        issue(1, 3'd6, 0, 0, rand_par(), 0, 0, 4'd9);
        issue(1, 3'd0, 0, 0, 0, 0, 0, 4'd2);

        issue(1, 3'd4, 0, 0, rand_par(), 0, 0, 0);
        feed(4, 1'b0);
        idle(12);

        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 11));
            if (sel == 0) begin
                feed(0, 1'($urandom_range(0, 1)));
            end else begin
                o = 3'($urandom_range(0, 7));
                if (o == 3'd5) o = 3'd3;
                issue(($urandom_range(0, 4) != 0), o, AW'($urandom_range(0, 15)), $urandom,
                      rand_par(), $urandom, $urandom, AW'($urandom_range(0, 15)));
            end
        end
        idle(12);
        chk("scoreboard_drained", NR*W'(exp_q.size()), '0);
        chk("ff_done_count", NR*W'(ff_seen), NR*W'(ff_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
